vector_mem_unit: RTL

//  Vector load/store unit. Moves one 128-bit vector register to/from 32-bit data memory as 4 word beats.

---
 rtl/vector_mem_pkg.sv | 33 +++
 rtl/vector_mem_if.sv | 29 ++
 rtl/vec_lane_buffer.sv | 45 ++++
 rtl/vector_mem_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/vector_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mem_pkg
//  Description : Shared types and constants for the vector load/store unit.
//                Holds the FSM state type, beat geometry and a lane-slice
//                helper used wherever a 32-bit lane is picked out of a vector.
//  Revision    : 1.0  initial release
// ============================================================================
package vector_mem_pkg;

    localparam int VM_DATA_W  = 128;
    localparam int VM_WORD_W  = 32;
    localparam int BEATS      = VM_DATA_W / VM_WORD_W;
    localparam int WORD_BYTES = VM_WORD_W / 8;
    localparam int BEAT_W     = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Lane 0 is the least significant word (little-endian lane order).
    function automatic logic [VM_WORD_W-1:0] lane_slice(
        input logic [VM_DATA_W-1:0] v,
        input logic [BEAT_W-1:0]    idx
    );
        return v[idx*VM_WORD_W +: VM_WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mem_if
//  Description : Word-wide data-memory beat bus between the vector load/store
//                unit (master) and data memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface vector_mem_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/vec_lane_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : vec_lane_buffer
//  Description : 128-bit vector staging register built from 32-bit lanes.
//                Parallel load of the whole vector, per-lane word writes and
//                a word-select read port. Parallel load has priority.
//  Revision    : 1.0  initial release
// ============================================================================
module vec_lane_buffer
    import vector_mem_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 load_en,
    input  wire logic [VM_DATA_W-1:0] load_data,
    input  wire logic [BEATS-1:0]     lane_we,
    input  wire logic [VM_WORD_W-1:0] lane_wdata,
    input  wire logic [BEAT_W-1:0]    rd_sel,
    output logic      [VM_WORD_W-1:0] rd_word,
    output logic      [VM_DATA_W-1:0] q
);

    generate
        for (genvar g = 0; g < BEATS; g++) begin : g_lane
            logic [VM_WORD_W-1:0] r_word;

            // One lane: whole-vector load wins over a single-lane write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_word <= '0;
                end else if (load_en) begin
                    r_word <= load_data[g*VM_WORD_W +: VM_WORD_W];
                end else if (lane_we[g]) begin
                    r_word <= lane_wdata;
                end
            end

            assign q[g*VM_WORD_W +: VM_WORD_W] = r_word;
        end
    endgenerate

    assign rd_word = lane_slice(q, rd_sel);

endmodule
`default_nettype wire

// File: rtl/vector_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mem_unit
//  Description : Vector load/store unit. Moves one 128-bit vector register
//                to/from 32-bit data memory as four word beats. Loads gather
//                four words and write the register file once; stores scatter
//                the latched register value as four word writes.
//  Revision    : 1.0  initial release
// ============================================================================
module vector_mem_unit
    import vector_mem_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              is_store,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [REG_AW-1:0] vreg,
    input  wire logic [DATA_W-1:0] store_data,
    output logic                   busy,
    output logic                   done,
    output logic                   vrf_wre,
    output logic      [REG_AW-1:0] vrf_a3,
    output logic      [DATA_W-1:0] vrf_wd3,
    vector_mem_if.master           mem_bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_is_store;
    logic [ADDR_W-1:0]   r_base;
    logic [REG_AW-1:0]   r_vreg;

    logic                w_accept;
    logic                w_beat_done;
    logic                w_last_beat;
    logic [BEATS-1:0]    w_lane_we;
    logic [WORD_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_buf_q;
    logic [DATA_W-1:0]   w_load_data;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_beat_done = (r_state == XFER) && mem_bus.mem_ready;
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

    // Stores preload the buffer with the register value; loads start from a
    // clean buffer so no stale data from an earlier operation can leak.
    assign w_load_data = is_store ? store_data : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_nxt = XFER;
            XFER: if (w_beat_done && w_last_beat) w_state_nxt = r_is_store ? DONE : WB;
            WB:   w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command latch and beat counter; the beat only advances on an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat     <= '0;
            r_is_store <= 1'b0;
            r_base     <= '0;
            r_vreg     <= '0;
        end else if (w_accept) begin
            r_beat     <= '0;
            r_is_store <= is_store;
            r_base     <= base_addr;
            r_vreg     <= vreg;
        end else if (w_beat_done) begin
            r_beat     <= w_last_beat ? '0 : r_beat + 1'b1;
        end
    end

    // Load beats capture memory read data into the lane being transferred
    always_comb begin
        w_lane_we = '0;
        if (w_beat_done && !r_is_store) begin
            w_lane_we[r_beat] = 1'b1;
        end
    end

    vec_lane_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (w_accept),
        .load_data  (w_load_data),
        .lane_we    (w_lane_we),
        .lane_wdata (mem_bus.mem_rdata),
        .rd_sel     (r_beat),
        .rd_word    (w_rd_word),
        .q          (w_buf_q)
    );

    // Memory side: everything decodes from registered state, so a stalled
    // beat (mem_ready low) naturally holds address and data steady.
    assign mem_bus.mem_req   = (r_state == XFER);
    assign mem_bus.mem_we    = (r_state == XFER) && r_is_store;
    assign mem_bus.mem_addr  = (r_state == XFER)
                             ? r_base + (ADDR_W'(r_beat) * ADDR_W'(WORD_BYTES))
                             : '0;
    assign mem_bus.mem_wdata = (r_state == XFER) ? w_rd_word : '0;

    // Register-file write port samples on the falling edge, hence purely
    // registered sources with no input-to-output path.
    assign vrf_wre = (r_state == WB);
    assign vrf_a3  = (r_state == WB) ? r_vreg  : '0;
    assign vrf_wd3 = (r_state == WB) ? w_buf_q : '0;

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule
`default_nettype wire
